// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Mini-SRC ALU opcode codes and multi-cycle FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_SHR  = 5'b00101;
  localparam logic [4:0] c_OP_SHRA = 5'b00110;
  localparam logic [4:0] c_OP_SHL  = 5'b00111;
  localparam logic [4:0] c_OP_ROR  = 5'b01000;
  localparam logic [4:0] c_OP_ROL  = 5'b01001;
  localparam logic [4:0] c_OP_AND  = 5'b01010;
  localparam logic [4:0] c_OP_OR   = 5'b01011;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_ANDI = 5'b01101;
  localparam logic [4:0] c_OP_ORI  = 5'b01110;
  localparam logic [4:0] c_OP_MUL  = 5'b01111;
  localparam logic [4:0] c_OP_DIV  = 5'b10000;
  localparam logic [4:0] c_OP_NEG  = 5'b10001;
  localparam logic [4:0] c_OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Restoring divider on operand magnitudes, one step per cycle,
//               with combinational sign fix of quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module div_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Remainder stays below the divisor magnitude, so the top bit of w_diff is a clean borrow.
  assign w_shift = {r_r, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
      r_d     <= i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
      r_r     <= '0;
      r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_neg_r <= i_dividend[WIDTH-1];
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_r <= w_diff[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= w_shift[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quot = r_neg_q ? -r_q : r_q;
  assign o_rem  = r_neg_r ? -r_r : r_r;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle Mini-SRC ALU: single-cycle ops, Booth MUL and
//               restoring DIV into HI/LO with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero
);

  localparam int             c_SHW  = $clog2(WIDTH);
  localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

  alu_state_t           r_state;
  logic [c_SHW-1:0]     r_cnt;
  logic [2*WIDTH+1:0]   r_prod;
  logic [WIDTH:0]       r_mcand;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dz;

  logic [c_SHW-1:0]          w_sh;
  logic [WIDTH-1:0]          w_alu;
  logic [WIDTH:0]            w_upper;
  logic [WIDTH:0]            w_sum;
  logic signed [2*WIDTH+1:0] w_cat;
  logic signed [2*WIDTH+1:0] w_next;
  logic                      w_div_load;
  logic [WIDTH-1:0]          w_quot;
  logic [WIDTH-1:0]          w_rem;

  assign w_sh = B[c_SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (opcode)
      c_OP_ADD, c_OP_ADDI: w_alu = A + B;
      c_OP_SUB:            w_alu = A - B;
      c_OP_SHR:            w_alu = A >> w_sh;
      c_OP_SHRA:           w_alu = $signed(A) >>> w_sh;
      c_OP_SHL:            w_alu = A << w_sh;
      c_OP_ROR:            w_alu = (A >> w_sh) | (A << (WIDTH - int'(w_sh)));
      c_OP_ROL:            w_alu = (A << w_sh) | (A >> (WIDTH - int'(w_sh)));
      c_OP_AND, c_OP_ANDI: w_alu = A & B;
      c_OP_OR, c_OP_ORI:   w_alu = A | B;
      c_OP_NEG:            w_alu = -A;
      c_OP_NOT:            w_alu = ~A;
      default:             w_alu = '0;
    endcase
  end

  // Booth accumulator carries one guard bit so the most-negative multiplicand cannot overflow.
  assign w_upper = r_prod[2*WIDTH+1:WIDTH+1];

  always_comb begin
    w_sum = w_upper;
    case (r_prod[1:0])
      2'b01:   w_sum = w_upper + r_mcand;
      2'b10:   w_sum = w_upper - r_mcand;
      default: w_sum = w_upper;
    endcase
  end

  assign w_cat  = {w_sum, r_prod[WIDTH:0]};
  assign w_next = w_cat >>> 1;

  assign w_div_load = (r_state == IDLE) && start && (opcode == c_OP_DIV) && (B != '0);

  div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk        (clock),
    .rst        (clear),
    .i_load     (w_div_load),
    .i_step     (r_state == DIV),
    .i_dividend (A),
    .i_divisor  (B),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dz  <= 1'b0;
            r_cnt <= '0;
            if (opcode == c_OP_MUL) begin
              r_state <= MUL;
              r_prod  <= {{(WIDTH+1){1'b0}}, B, 1'b0};
              r_mcand <= {A[WIDTH-1], A};
            end else if (opcode == c_OP_DIV) begin
              if (B == '0) begin
                r_lo     <= '1;
                r_hi     <= A;
                r_result <= '1;
                r_dz     <= 1'b1;
                r_done   <= 1'b1;
              end else begin
                r_state <= DIV;
              end
            end else begin
              r_result <= w_alu;
              r_done   <= 1'b1;
            end
          end
        end
        MUL: begin
          r_prod <= w_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state  <= IDLE;
            r_hi     <= w_next[2*WIDTH:WIDTH+1];
            r_lo     <= w_next[WIDTH:1];
            r_result <= w_next[WIDTH:1];
            r_done   <= 1'b1;
          end
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_state  <= IDLE;
          r_hi     <= w_rem;
          r_lo     <= w_quot;
          r_result <= w_quot;
          r_done   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the Mini-SRC datapath. It executes the R-format and immediate ALU opcodes in one cycle, and signed MUL and DIV iteratively. The 2×WIDTH product and the quotient/remainder go into internal HI/LO registers. A start/busy/done handshake lets the control unit stall while a multi-cycle operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be ≥4 and a power of two.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  sampled only in IDLE; launches the operation in opcode.
- opcode  in  5  Mini-SRC opcode.
- A, B  in  WIDTH  operands, captured on the accepted start edge.
- busy  out  1  high while MUL/DIV iterates.
- done  out  1  one-cycle pulse when result/HI/LO are valid.
- result  out  WIDTH  registered result; equals LO for MUL/DIV.
- HI, LO  out  WIDTH  registered MUL/DIV outputs.
- div_zero  out  1  set with done when DIV had B=0; cleared on next accepted start.

## Operation
- Opcodes:
  - add/addi 00011/01100: A+B.
  - sub 00100: A−B.
  - shr 00101: logical right shift.
  - shra 00110: arithmetic right shift.
  - shl 00111: left shift.
  - ror 01000, rol 01001: rotates.
  - and/andi 01010/01101, or/ori 01011/01110.
  - mul 01111, div 10000.
  - neg 10001: −A.
  - not 10010: ~A.
- Shift/rotate amount is B[log2(WIDTH)−1:0]; upper bits of B are ignored.
- Add, sub and neg wrap modulo 2^WIDTH; no flags.
- Any other opcode: result=0, done pulses, HI/LO unchanged.
- Single-cycle ops update result only; HI/LO hold.
- MUL: signed radix-2 Booth, WIDTH iterations; {HI,LO} = A×B, 2×WIDTH signed.
- DIV: restoring on magnitudes, WIDTH iterations, then one sign-fix cycle.
  - LO = quotient, truncated toward zero.
  - HI = remainder, sign of dividend.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
  - B=0: no iteration; LO = all-ones, HI = A, div_zero=1.
- State machine:
  - IDLE: start & (mul|div) → MUL or DIV, with busy=1; other start → IDLE, with done next edge.
  - MUL: counter reaches WIDTH−1 → IDLE, writing HI/LO/result and pulsing done.
  - DIV: counter reaches WIDTH−1 → FIX.
  - FIX: apply signs, write HI/LO/result, pulse done → IDLE.
- start while busy=1 is ignored; no queuing.
- clear, at any state including mid-iteration, aborts the operation; next cycle the block is in IDLE.

## Timing
- Reset values: busy=0, done=0, result=0, HI=0, LO=0, div_zero=0, state IDLE, counter 0.
- start accepted at edge N. Results valid and done=1 in the cycle after:
  - single-cycle ops and DIV-by-zero: edge N+1.
  - MUL: edge N+WIDTH+1.
  - DIV: edge N+WIDTH+2.
- busy rises at edge N+1 for MUL/DIV and falls on the same edge done rises.
- A new start may be accepted in the cycle done is high; back-to-back single-cycle ops give one result per cycle.
- Outputs hold their last value until the next completing operation or clear.

## Structure
- Package alu_pkg:
  - opcode localparams (5-bit codes above).
  - state enum {IDLE, MUL, DIV, FIX}.
- Sub-module div_core: restoring divider datapath with magnitude/sign-fix logic, one step per cycle. It is driven by alu_mc's counter and FSM.
- Booth step and single-cycle ops stay inline in alu_mc.

## Test plan
All scenarios use WIDTH=32.
- Wrap and logic: add 0x7FFFFFFF+0x1 → result 0x80000000 with done at N+1, HI/LO unchanged. Then not 0x0F0F0F0F → 0xF0F0F0F0.
- Shifts, each with done at N+1:
  - rol 0x80000001 by 4 → 0x00000018.
  - ror 0x00000001 by 1 → 0x80000000.
  - shra 0x80000000 by 4 → 0xF8000000.
  - shr by B=0x24 (amount 4) → logical shift by 4.
- MUL: A=0xFFFFFFFD (−3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB, result=LO. done exactly at N+33, busy high for 32 cycles. Repeat with 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV:
  - −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, done at N+34.
  - 0x80000000÷0xFFFFFFFF → LO=0x80000000, HI=0.
  - 5÷0 → LO=0xFFFFFFFF, HI=5, div_zero=1, done at N+1.
- Handshake: start an add while MUL is busy → ignored, MUL result intact. Start a new op in the done cycle → accepted.
- clear at cycle 10 of a MUL → next cycle busy=0, HI=LO=result=0, no done pulse. A subsequent div 100÷7 → LO=14, HI=2.
